dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared state encoding and default sizing for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int c_default_depth = 1024;
    localparam int c_default_wait  = 2;
    localparam int c_cnt_w         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port DEPTH x 32 storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Contents are deliberately not reset.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Valid/ready data-memory responder with fixed wait states and
//            misaligned / out-of-range access rejection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = c_default_depth,
    parameter int WAIT_CYCLES = c_default_wait
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                 c_aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_init = c_cnt_w'(WAIT_CYCLES);

    dmem_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_write;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic               r_req_ready;
    logic               r_rsp_valid;

    logic               w_reject;
    logic               w_mem_we;
    logic [31:0]        w_mem_rdata;

    assign w_reject = (r_addr[1:0] != 2'b00) ||
                      ({2'b00, r_addr[31:2]} >= $unsigned(DEPTH));

    // The store lands only on the WAIT->RESP edge, so an async reset in WAIT drops it.
    assign w_mem_we = (r_state == WAIT) && (r_cnt == '0) && r_write && !w_reject;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_aw)
    ) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (r_addr[c_aw+1:2]),
        .wdata (r_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= c_wait_init;
                        r_state     <= WAIT;
                        r_req_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_err       <= w_reject;
                        r_rdata     <= (!w_reject && !r_write) ? w_mem_rdata : 32'h0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Randomized self-checking bench for dmem_responder against a word-map model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int c_depth = 1024;
    localparam int c_wait  = 2;

    logic        clk;
    logic        reset;

    logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        req_valid_z, req_write_z, req_ready_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [int unsigned];

    dmem_responder #(.DEPTH(c_depth), .WAIT_CYCLES(c_wait)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH(c_depth), .WAIT_CYCLES(0)) dut_z (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_z),
        .req_write (req_write_z),
        .req_addr  (req_addr_z),
        .req_wdata (req_wdata_z),
        .req_ready (req_ready_z),
        .rsp_valid (rsp_valid_z),
        .rsp_ready (rsp_ready_z),
        .rsp_rdata (rsp_rdata_z),
        .rsp_err   (rsp_err_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit rejected(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= c_depth);
    endfunction

    // One full transaction on the default DUT; starts and ends just after a rising edge.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input bit early, input string tag);
        bit          exp_err;
        bit          known;
        logic [31:0] exp_data;
        logic [31:0] got_data;
        logic        got_err;
        int          lat;

        exp_err  = rejected(addr);
        known    = 1'b1;
        exp_data = 32'h0;
        if (!wr && !exp_err) begin
            if (model.exists(addr / 4)) exp_data = model[addr / 4];
            else                        known    = 1'b0;
        end

        chk({tag, "_idle_rdy"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = early;
        @(posedge clk);
        #1;
        chk({tag, "_busy_rdy"}, {31'h0, req_ready}, 32'h0);
        // Junk on the request bus while busy must be ignored.
        req_valid = $urandom_range(0, 1);
        req_write = 1'b1;
        req_addr  = 32'($urandom_range(0, 15)) * 4;
        req_wdata = $urandom();

        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, c_wait + 1);
        got_data = rsp_rdata;
        got_err  = rsp_err;
        chk({tag, "_err"}, {31'h0, got_err}, {31'h0, exp_err});
        if (known) chk({tag, "_data"}, got_data, exp_data);
        if (wr && !exp_err) model[addr / 4] = wdata;

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'($urandom_range(0, 15)) * 4;
            req_wdata = $urandom();
            @(posedge clk);
            #1;
            chk({tag, "_hold_vld"}, {31'h0, rsp_valid}, 32'h1);
            chk({tag, "_hold_data"}, rsp_rdata, got_data);
            chk({tag, "_hold_err"}, {31'h0, rsp_err}, {31'h0, got_err});
            chk({tag, "_hold_rdy"}, {31'h0, req_ready}, 32'h0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_done_vld"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_done_rdy"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        int          kind;
        int          idx;
        logic [31:0] a;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        rsp_ready   = 1'b0;
        req_valid_z = 1'b0;
        req_write_z = 1'b0;
        req_addr_z  = 32'h0;
        req_wdata_z = 32'h0;
        rsp_ready_z = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        reset = 1'b0;

        access(1'b1, 32'h0,   32'h1111_1111, 0, 1'b0, "pre0");
        access(1'b1, 32'h4,   32'h2222_2222, 0, 1'b0, "pre4");
        access(1'b1, 32'h8,   32'h3333_3333, 0, 1'b0, "pre8");
        access(1'b1, 32'h10,  32'h0,         0, 1'b0, "pre10");
        access(1'b1, 32'hFFC, 32'h4444_4444, 0, 1'b0, "preffc");

        access(1'b1, 32'hFC4, 32'h0000_0400, 0, 1'b1, "st_fc4");
        access(1'b0, 32'hFC4, 32'h0,         0, 1'b1, "ld_fc4");

        access(1'b0, 32'h8, 32'h0, 5, 1'b0, "ld_hold");

        access(1'b1, 32'h6,    32'hBAD0_0006, 0, 1'b0, "st_misal");
        access(1'b1, 32'h1000, 32'hBAD0_1000, 0, 1'b0, "st_oor");
        access(1'b0, 32'h4,    32'h0, 0, 1'b0, "ld_4");
        access(1'b0, 32'hFFC,  32'h0, 0, 1'b0, "ld_ffc");
        access(1'b0, 32'h0,    32'h0, 0, 1'b0, "ld_0");

        // Reset one cycle into the wait phase of a store.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        access(1'b0, 32'h10, 32'h0, 0, 1'b0, "ld_10");

        // Reset while a response is pending.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstr_pre_data", rsp_rdata, 32'h3333_3333);
        reset = 1'b1;
        #1;
        chk("rstr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstr_rsp_rdata", rsp_rdata, 32'h0);
        chk("rstr_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            access(1'b1, 32'(k) * 4, $urandom(), 0, 1'b0, "rnd_pre");
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            if (kind < 8)       a = 32'(idx) * 4;
            else if (kind == 8) a = 32'(idx) * 4 + 32'($urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 1) a = 32'(c_depth + idx) * 4;
            else                a = ($urandom() & 32'hFFFF_FFFC) | 32'h8000_0000;
            if ($urandom_range(0, 1) == 1) begin
                access($urandom_range(0, 1) == 1, a, $urandom(), 0, 1'b1, "rnd");
            end else begin
                access($urandom_range(0, 1) == 1, a, $urandom(), $urandom_range(0, 3), 1'b0, "rnd");
            end
        end

        // Zero wait states: back-to-back store then load, three cycles each.
        for (int k = 0; k < 2; k++) begin
            req_valid_z = 1'b1;
            req_write_z = (k == 0);
            req_addr_z  = 32'h20;
            req_wdata_z = 32'hA5A5_5A5A;
            chk("z_idle_rdy", {31'h0, req_ready_z}, 32'h1);
            @(posedge clk);
            #1;
            chk("z_wait_rdy", {31'h0, req_ready_z}, 32'h0);
            chk("z_wait_vld", {31'h0, rsp_valid_z}, 32'h0);
            @(posedge clk);
            #1;
            chk("z_resp_vld",  {31'h0, rsp_valid_z}, 32'h1);
            chk("z_resp_err",  {31'h0, rsp_err_z}, 32'h0);
            chk("z_resp_data", rsp_rdata_z, (k == 0) ? 32'h0 : 32'hA5A5_5A5A);
            @(posedge clk);
            #1;
            chk("z_back_rdy", {31'h0, req_ready_z}, 32'h1);
            chk("z_back_vld", {31'h0, rsp_valid_z}, 32'h0);
        end
        req_valid_z = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
